// File: rtl/rc5_decipher.sv
// ============================================================================
// Module   : rc5_decipher
// Purpose  : RC5-W/R block decryption engine. Runs the R rounds in reverse
//            order against an external synchronous key RAM (expanded table S),
//            then removes the input whitening. Three cycles per round: one
//            key-RAM access cycle, one cycle for B and one cycle for A.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            iStart       - start request, sampled only in IDLE
//            iA, iB       - ciphertext words, captured with iStart
//            oS_address1  - key RAM address of S[2i]   (registered)
//            oS_address2  - key RAM address of S[2i+1] (registered)
//            iS_sub_i1/2  - key RAM read data, one cycle after the address
//            oA_plain     - plaintext word A, updated only on completion
//            oB_plain     - plaintext word B, updated only on completion
//            oBusy        - high outside IDLE (only with DECIPHER_BUSY_EN)
//            oDone        - one-cycle completion pulse
// Options  : DECIPHER_BUSY_EN - adds the registered oBusy output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc5_decipher #(
    parameter int W         = 32,
    parameter int R         = 12,
    parameter int ROT_VALUE = $clog2(W),
    parameter int T         = 2 * (R + 1),
    parameter int T_LENGTH  = $clog2(T)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic [W-1:0]        iA,
    input  logic [W-1:0]        iB,
    output logic [T_LENGTH-1:0] oS_address1,
    output logic [T_LENGTH-1:0] oS_address2,
    input  logic [W-1:0]        iS_sub_i1,
    input  logic [W-1:0]        iS_sub_i2,
    output logic [W-1:0]        oA_plain,
    output logic [W-1:0]        oB_plain,
`ifdef DECIPHER_BUSY_EN
    output logic                oBusy,
`endif
    output logic                oDone
);

    localparam int CNT_W = $clog2(R + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RD  = 3'd1,
        ROUND_B  = 3'd2,
        ROUND_A  = 3'd3,
        WAIT_FIN = 3'd4,
        FINAL    = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       work_a;
    logic [W-1:0]       work_b;
    logic [CNT_W-1:0]   round_cnt;
    logic [W-1:0]       b_round;
    logic [W-1:0]       a_round;

    function automatic logic [W-1:0] ror(input logic [W-1:0] x,
                                         input logic [ROT_VALUE-1:0] n);
        logic [2*W-1:0] doubled;
        doubled = {x, x} >> n;
        return doubled[W-1:0];
    endfunction

    // Inverse half-rounds. The A step sees work_b after ROUND_B has
    // already written it, which is exactly the reverse of the cipher order.
    assign b_round = ror(work_b - iS_sub_i2, work_a[ROT_VALUE-1:0]) ^ work_a;
    assign a_round = ror(work_a - iS_sub_i1, work_b[ROT_VALUE-1:0]) ^ work_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (iStart) state_next = WAIT_RD;
            WAIT_RD:  state_next = ROUND_B;
            ROUND_B:  state_next = ROUND_A;
            ROUND_A:  state_next = (round_cnt == CNT_W'(1)) ? WAIT_FIN : WAIT_RD;
            WAIT_FIN: state_next = FINAL;
            FINAL:    state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_a      <= '0;
            work_b      <= '0;
            round_cnt   <= '0;
            oS_address1 <= T_LENGTH'(0);
            oS_address2 <= T_LENGTH'(1);
            oA_plain    <= '0;
            oB_plain    <= '0;
            oDone       <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        work_a      <= iA;
                        work_b      <= iB;
                        round_cnt   <= CNT_W'(R);
                        oS_address1 <= T_LENGTH'(2 * R);
                        oS_address2 <= T_LENGTH'(2 * R + 1);
                    end
                end
                ROUND_B: begin
                    work_b <= b_round;
                end
                ROUND_A: begin
                    work_a <= a_round;
                    if (round_cnt == CNT_W'(1)) begin
                        // Point at the whitening keys S[0], S[1]; they stay
                        // selected until the next start.
                        oS_address1 <= T_LENGTH'(0);
                        oS_address2 <= T_LENGTH'(1);
                    end else begin
                        round_cnt   <= round_cnt - CNT_W'(1);
                        oS_address1 <= oS_address1 - T_LENGTH'(2);
                        oS_address2 <= oS_address2 - T_LENGTH'(2);
                    end
                end
                FINAL: begin
                    oA_plain <= work_a - iS_sub_i1;
                    oB_plain <= work_b - iS_sub_i2;
                    oDone    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DECIPHER_BUSY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oBusy <= 1'b0;
        end else begin
            oBusy <= (state_next != IDLE);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rc5_decipher.sv
// ============================================================================
// Module   : tb_rc5_decipher
// Purpose  : Directed self-checking bench for rc5_decipher (RC5-32/12) with a
//            synchronous one-cycle-latency key RAM model, an independent key
//            expansion and an encryption model for round-trip vectors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rc5_decipher;

    localparam int W  = 32;
    localparam int R  = 12;
    localparam int T  = 2 * (R + 1);
    localparam int TL = $clog2(T);

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          iStart = 1'b0;
    logic [W-1:0]  iA     = '0;
    logic [W-1:0]  iB     = '0;
    logic [TL-1:0] addr1;
    logic [TL-1:0] addr2;
    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [W-1:0]  a_plain;
    logic [W-1:0]  b_plain;
    logic          done;
`ifdef DECIPHER_BUSY_EN
    logic          busy;
`endif

    logic [W-1:0]  key_ram [0:T-1];
    int            checks = 0;
    int            errors = 0;

    rc5_decipher #(.W(W), .R(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .iStart      (iStart),
        .iA          (iA),
        .iB          (iB),
        .oS_address1 (addr1),
        .oS_address2 (addr2),
        .iS_sub_i1   (s1),
        .iS_sub_i2   (s2),
        .oA_plain    (a_plain),
        .oB_plain    (b_plain),
`ifdef DECIPHER_BUSY_EN
        .oBusy       (busy),
`endif
        .oDone       (done)
    );

    always #5 clk = ~clk;

    // Synchronous key RAM, one cycle read latency.
    always @(posedge clk) begin
        s1 <= key_ram[addr1];
        s2 <= key_ram[addr2];
    end

    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [31:0] n);
        logic [63:0] d;
        logic [4:0]  sh;
        sh = n[4:0];
        d  = {v, v} << sh;
        return d[63:32];
    endfunction

    task automatic load_zero_key();
        for (int k = 0; k < T; k++) key_ram[k] = '0;
    endtask

    // RC5-32/12 key schedule for the all-zero 16-byte key.
    task automatic load_expanded_key();
        logic [31:0] s [0:T-1];
        logic [31:0] l [0:3];
        logic [31:0] x, y;
        int i, j;
        s[0] = 32'hB7E15163;
        for (int k = 1; k < T; k++) s[k] = s[k-1] + 32'h9E3779B9;
        for (int k = 0; k < 4; k++) l[k] = '0;
        x = '0; y = '0; i = 0; j = 0;
        for (int k = 0; k < 3 * T; k++) begin
            x    = rol32(s[i] + x + y, 32'd3);
            s[i] = x;
            y    = rol32(l[j] + x + y, x + y);
            l[j] = y;
            i    = (i + 1) % T;
            j    = (j + 1) % 4;
        end
        for (int k = 0; k < T; k++) key_ram[k] = s[k];
    endtask

    task automatic encrypt(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ca, output logic [31:0] cb);
        logic [31:0] x, y;
        x = a + key_ram[0];
        y = b + key_ram[1];
        for (int i = 1; i <= R; i++) begin
            x = rol32(x ^ y, y) + key_ram[2*i];
            y = rol32(y ^ x, x) + key_ram[2*i+1];
        end
        ca = x;
        cb = y;
    endtask

    // Starts one operation and waits (bounded) for oDone. lat is the number
    // of edges after the start edge at which oDone was seen, -1 if never.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] pa, output logic [31:0] pb,
                          output int lat);
        @(negedge clk);
        iStart = 1'b1; iA = a; iB = b;
        @(negedge clk);
        iStart = 1'b0; iA = $urandom; iB = $urandom;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        pa = a_plain;
        pb = b_plain;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (addr1 !== 5'd0) begin errors++; $display("FAIL reset_addr1: got %0d expected 0", addr1); end
        checks++; if (addr2 !== 5'd1) begin errors++; $display("FAIL reset_addr2: got %0d expected 1", addr2); end
        checks++; if (a_plain !== 32'h0) begin errors++; $display("FAIL reset_a_plain: got %h expected 0", a_plain); end
        checks++; if (b_plain !== 32'h0) begin errors++; $display("FAIL reset_b_plain: got %h expected 0", b_plain); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef DECIPHER_BUSY_EN
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [31:0] pa, pb;
        int lat;
        load_zero_key();
        run_op(32'h0, 32'h0, pa, pb, lat);
        checks++; if (lat != 38) begin errors++; $display("FAIL zero_latency: got %0d expected 38", lat); end
        checks++; if (pa !== 32'h0) begin errors++; $display("FAIL zero_a: got %h expected 0", pa); end
        checks++; if (pb !== 32'h0) begin errors++; $display("FAIL zero_b: got %h expected 0", pb); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", done); end
    endtask

    task automatic test_known_answer();
        logic [31:0] pa, pb;
        int lat;
        load_expanded_key();
        run_op(32'hEEDBA521, 32'h6D8F4B15, pa, pb, lat);
        checks++; if (lat != 38) begin errors++; $display("FAIL kat_latency: got %0d expected 38", lat); end
        checks++; if (pa !== 32'h0) begin errors++; $display("FAIL kat_a: got %h expected 0", pa); end
        checks++; if (pb !== 32'h0) begin errors++; $display("FAIL kat_b: got %h expected 0", pb); end
    endtask

    task automatic test_round_trip();
        logic [31:0] a, b, ca, cb, pa, pb;
        int lat;
        for (int n = 0; n <= 20; n++) begin
            if (n == 0) begin
                a = 32'h12345678; b = 32'h9ABCDEF0;
            end else begin
                a = $urandom; b = $urandom;
            end
            encrypt(a, b, ca, cb);
            run_op(ca, cb, pa, pb, lat);
            checks++; if (lat != 38) begin errors++; $display("FAIL rt_latency[%0d]: got %0d expected 38", n, lat); end
            checks++; if (pa !== a) begin errors++; $display("FAIL rt_a[%0d]: got %h expected %h", n, pa, a); end
            checks++; if (pb !== b) begin errors++; $display("FAIL rt_b[%0d]: got %h expected %h", n, pb, b); end
            if (n == 0) begin
                repeat (6) @(negedge clk);
                checks++; if (a_plain !== a) begin errors++; $display("FAIL rt_hold_a: got %h expected %h", a_plain, a); end
                checks++; if (b_plain !== b) begin errors++; $display("FAIL rt_hold_b: got %h expected %h", b_plain, b); end
            end
        end
    endtask

    task automatic test_address_order();
        logic [31:0] a, b, ca, cb;
        logic [4:0]  e1;
        int          dones;
        a = 32'hCAFEF00D; b = 32'h0BADBEEF;
        encrypt(a, b, ca, cb);
        dones = 0;
        @(negedge clk);
        iStart = 1'b1; iA = ca; iB = cb;
        @(negedge clk);
        iA = $urandom; iB = $urandom;
        for (int c = 0; c <= 39; c++) begin
            if (c > 0) @(negedge clk);
            e1 = (c < 36) ? 5'(24 - 2 * (c / 3)) : 5'd0;
            checks++; if (addr1 !== e1) begin errors++; $display("FAIL addr1[c%0d]: got %0d expected %0d", c, addr1, e1); end
            checks++; if (addr2 !== e1 + 5'd1) begin errors++; $display("FAIL addr2[c%0d]: got %0d expected %0d", c, addr2, e1 + 5'd1); end
            checks++; if (done !== (c == 38)) begin errors++; $display("FAIL addr_done[c%0d]: got %b expected %b", c, done, (c == 38)); end
            if (done === 1'b1) dones++;
        end
        iStart = 1'b0;
        checks++; if (dones != 1) begin errors++; $display("FAIL addr_done_count: got %0d expected 1", dones); end
        checks++; if (a_plain !== a) begin errors++; $display("FAIL addr_a: got %h expected %h", a_plain, a); end
        checks++; if (b_plain !== b) begin errors++; $display("FAIL addr_b: got %h expected %h", b_plain, b); end
        repeat (5) @(negedge clk);
        checks++; if (addr1 !== 5'd0) begin errors++; $display("FAIL addr_no_restart: got %0d expected 0", addr1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, ca, cb, pa, pb;
        int lat, dones;
        @(negedge clk);
        iStart = 1'b1; iA = $urandom; iB = $urandom;
        @(negedge clk);
        iStart = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (addr1 !== 5'd18) begin errors++; $display("FAIL mid_pre_addr1: got %0d expected 18", addr1); end
        rst = 1'b0;
        #1;
        checks++; if (addr1 !== 5'd0) begin errors++; $display("FAIL mid_addr1: got %0d expected 0", addr1); end
        checks++; if (addr2 !== 5'd1) begin errors++; $display("FAIL mid_addr2: got %0d expected 1", addr2); end
        checks++; if (a_plain !== 32'h0) begin errors++; $display("FAIL mid_a_plain: got %h expected 0", a_plain); end
        checks++; if (b_plain !== 32'h0) begin errors++; $display("FAIL mid_b_plain: got %h expected 0", b_plain); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL mid_spurious_done: got %0d expected 0", dones); end
        a = 32'h00000001; b = 32'hFFFFFFFF;
        encrypt(a, b, ca, cb);
        run_op(ca, cb, pa, pb, lat);
        checks++; if (lat != 38) begin errors++; $display("FAIL mid_restart_latency: got %0d expected 38", lat); end
        checks++; if (pa !== a) begin errors++; $display("FAIL mid_restart_a: got %h expected %h", pa, a); end
        checks++; if (pb !== b) begin errors++; $display("FAIL mid_restart_b: got %h expected %h", pb, b); end
    endtask

`ifdef DECIPHER_BUSY_EN
    task automatic test_busy();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b expected 0", busy); end
        iStart = 1'b1; iA = $urandom; iB = $urandom;
        @(negedge clk);
        iStart = 1'b0;
        for (int c = 0; c <= 39; c++) begin
            if (c > 0) @(negedge clk);
            checks++; if (busy !== (c <= 38)) begin errors++; $display("FAIL busy[c%0d]: got %b expected %b", c, busy, (c <= 38)); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_known_answer();
        test_round_trip();
        test_address_order();
        test_reset_mid();
`ifdef DECIPHER_BUSY_EN
        test_busy();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
